data_mem_responder: RTL and testbench

//  Responder end of the core's data-memory request interface; the core's control unit is the initiator.

---
 rtl/data_mem_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//   Responder end of the core's data-memory request interface. Accepts one
//   load/store at a time, waits a fixed access latency, then presents a
//   response that is held until the consumer accepts it. Stores update only
//   the addressed byte lanes; loads return sign- or zero-extended data.
//
// Handshake semantics (both channels): a transfer happens at a rising clock
//   edge where valid and ready are both 1. The request channel is ready only
//   in IDLE. A response, once valid, keeps resp_rdata/resp_err stable until
//   resp_ready is seen at an edge.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake
//   mem_read/mem_write  command (exactly one must be set)
//   mem_sign            0 = sign-extend load, 1 = zero-extend load
//   mem_width           00 byte, 01 half, 10 word, 11 double
//   addr, wdata         byte address and store data
//   resp_valid/ready    response handshake
//   resp_rdata          extended load data, 0 for stores and errors
//   resp_err            request rejected, no memory side effect
//   dbg_state           current FSM state (IDLE=0, WAIT=1, RESP=2)
// ---------------------------------------------------------------------------
module data_mem_responder #(
   parameter int REG_WIDTH   = 64,
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH_WORDS = 512,
   parameter int LATENCY     = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic                  mem_sign,
   input  logic [1:0]            mem_width,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [REG_WIDTH-1:0]  wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [REG_WIDTH-1:0]  resp_rdata,
   output logic                  resp_err,
   output logic [1:0]            dbg_state
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next_state;

   // Latched request
   logic             r_is_store;
   logic             r_req_err;
   logic             r_sign;
   logic [1:0]       r_width;
   logic [2:0]       r_off;
   logic [IDX_W-1:0] r_idx;
   logic [REG_WIDTH-1:0] r_wdata;
   logic [CNT_W-1:0] r_cnt;

   // Response registers
   logic [REG_WIDTH-1:0] r_rdata;
   logic                 r_resp_err;

   // RAM (not reset)
   logic [REG_WIDTH-1:0] r_mem [DEPTH_WORDS];

   logic                 w_accept;
   logic                 w_access;
   logic                 w_resp_done;
   logic [2:0]           w_off;
   logic [2:0]           w_align_mask;
   logic                 w_misalign;
   logic                 w_oor;
   logic                 w_bad_cmd;
   logic                 w_req_err;
   logic [7:0]           w_size_lanes;
   logic [7:0]           w_be;
   logic                 w_do_store;
   logic [REG_WIDTH-1:0] w_wdata_sh;
   logic [REG_WIDTH-1:0] w_word;
   logic [REG_WIDTH-1:0] w_word_sh;
   logic                 w_fill_en;
   logic [REG_WIDTH-1:0] w_ext;
   logic [REG_WIDTH-1:0] w_load_data;

   assign req_ready   = (r_state == ST_IDLE);
   assign resp_valid  = (r_state == ST_RESP);
   assign resp_rdata  = r_rdata;
   assign resp_err    = r_resp_err;
   assign dbg_state   = r_state;

   assign w_accept    = req_valid & req_ready;
   assign w_access    = (r_state == ST_WAIT) && (r_cnt == '0);
   assign w_resp_done = (r_state == ST_RESP) && resp_ready;

   // ---------------- request checks, evaluated on the live inputs ----------
   assign w_off = addr[2:0];

   always_comb begin
      w_align_mask = 3'b000;
      case (mem_width)
         2'b00:   w_align_mask = 3'b000;
         2'b01:   w_align_mask = 3'b001;
         2'b10:   w_align_mask = 3'b011;
         default: w_align_mask = 3'b111;
      endcase
   end

   assign w_misalign = |(w_off & w_align_mask);
   // Any address bit above the RAM index range means addr >= DEPTH_WORDS*8.
   assign w_oor      = |addr[ADDR_WIDTH-1:IDX_W+3];
   assign w_bad_cmd  = (mem_read == mem_write);
   assign w_req_err  = w_misalign | w_oor | w_bad_cmd;

   // ---------------- FSM ----------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)    w_next_state = ST_WAIT;
         ST_WAIT: if (w_access)    w_next_state = ST_RESP;
         ST_RESP: if (w_resp_done) w_next_state = ST_IDLE;
         default:                  w_next_state = ST_IDLE;
      endcase
   end

   // ---------------- request latch and wait counter -------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_is_store <= 1'b0;
         r_req_err  <= 1'b0;
         r_sign     <= 1'b0;
         r_width    <= 2'b00;
         r_off      <= 3'b000;
         r_idx      <= '0;
         r_wdata    <= '0;
         r_cnt      <= '0;
      end else if (w_accept) begin
         r_is_store <= mem_write;
         r_req_err  <= w_req_err;
         r_sign     <= mem_sign;
         r_width    <= mem_width;
         r_off      <= w_off;
         r_idx      <= addr[3 +: IDX_W];
         r_wdata    <= wdata;
         r_cnt      <= CNT_INIT;
      end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   // ---------------- store path ---------------------------------------------
   always_comb begin
      w_size_lanes = 8'h00;
      case (r_width)
         2'b00:   w_size_lanes = 8'h01;
         2'b01:   w_size_lanes = 8'h03;
         2'b10:   w_size_lanes = 8'h0F;
         default: w_size_lanes = 8'hFF;
      endcase
   end

   // Alignment was checked at latch time, so the shifted lanes never wrap.
   assign w_be       = w_size_lanes << r_off;
   assign w_wdata_sh = r_wdata << {r_off, 3'b000};
   // Async reset forces IDLE, so a store pending in WAIT can never fire.
   assign w_do_store = w_access & r_is_store & ~r_req_err;

   always_ff @(posedge clk) begin
      for (int b = 0; b < 8; b++) begin
         if (w_do_store && w_be[b]) r_mem[r_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
      end
   end

   // ---------------- load path ----------------------------------------------
   assign w_word    = r_mem[r_idx];
   assign w_word_sh = w_word >> {r_off, 3'b000};
   assign w_fill_en = ~r_sign;

   always_comb begin
      w_ext = '0;
      case (r_width)
         2'b00:   w_ext = {{56{w_word_sh[7]  & w_fill_en}}, w_word_sh[7:0]};
         2'b01:   w_ext = {{48{w_word_sh[15] & w_fill_en}}, w_word_sh[15:0]};
         2'b10:   w_ext = {{32{w_word_sh[31] & w_fill_en}}, w_word_sh[31:0]};
         default: w_ext = w_word_sh;
      endcase
   end

   assign w_load_data = (r_is_store | r_req_err) ? '0 : w_ext;

   // ---------------- response registers -------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata    <= '0;
         r_resp_err <= 1'b0;
      end else if (w_access) begin
         r_rdata    <= w_load_data;
         r_resp_err <= r_req_err;
      end else if (w_resp_done) begin
         r_rdata    <= '0;
         r_resp_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//   Self-checking bench for data_mem_responder. Expected values come from
//   directed constants and from a byte-array reference model of the RAM.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

   localparam int LAT   = 2;
   localparam int DEPTH = 512;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        mem_read;
   logic        mem_write;
   logic        mem_sign;
   logic [1:0]  mem_width;
   logic [31:0] addr;
   logic [63:0] wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic [1:0]  dbg_state;

   int n_total;
   int n_bad;

   logic [7:0] m_mem [DEPTH*8];

   data_mem_responder #(
      .REG_WIDTH(64), .ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .mem_read(mem_read), .mem_write(mem_write), .mem_sign(mem_sign),
      .mem_width(mem_width), .addr(addr), .wdata(wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic void model(input logic rd, input logic wr, input logic sg,
                                 input logic [1:0] w, input logic [31:0] a,
                                 input logic [63:0] wd,
                                 output logic [63:0] d, output logic e);
      int size;
      int off;
      size = 1 << w;
      off  = int'(a % 8);
      d = '0;
      e = ((off % size) != 0) || (a >= 32'(DEPTH*8)) || (rd == wr);
      if (e) return;
      if (wr) begin
         for (int i = 0; i < size; i++) m_mem[int'(a) + i] = wd[8*i +: 8];
         return;
      end
      for (int i = 0; i < size; i++) d[8*i +: 8] = m_mem[int'(a) + i];
      if (!sg && size < 8 && d[8*size-1]) begin
         for (int i = size; i < 8; i++) d[8*i +: 8] = 8'hFF;
      end
   endfunction

   // ---------------- driver ----------------
   task automatic issue(input logic rd, input logic wr, input logic sg,
                        input logic [1:0] w, input logic [31:0] a,
                        input logic [63:0] wd, input int stall,
                        output logic [63:0] d, output logic e);
      int cyc;
      logic [63:0] d0;
      logic        e0;
      d = '0;
      e = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; mem_read = rd; mem_write = wr; mem_sign = sg;
      mem_width = w; addr = a; wdata = wd;
      n_total++;
      if (req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL req_ready_idle got=%b exp=1", req_ready);
      end
      cyc = 0;
      while (req_ready !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      @(posedge clk);
      @(negedge clk);
      // Scramble inputs: the DUT must use only the latched copy.
      req_valid = 1'b0;
      mem_read  = 1'($urandom_range(0, 1));
      mem_write = 1'($urandom_range(0, 1));
      mem_sign  = 1'($urandom_range(0, 1));
      mem_width = 2'($urandom_range(0, 3));
      addr      = $urandom;
      wdata     = {$urandom, $urandom};
      cyc = 0;
      while (resp_valid !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      n_total++;
      if (resp_valid !== 1'b1 || cyc != LAT) begin
         n_bad++;
         $display("FAIL latency got_valid=%b got_cycles=%0d exp_cycles=%0d", resp_valid, cyc, LAT);
      end
      d0 = resp_rdata;
      e0 = resp_err;
      d  = d0;
      e  = e0;
      for (int s = 0; s < stall; s++) begin
         req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; addr = 32'h0; mem_width = 2'b11;
         @(negedge clk);
         n_total++;
         if (resp_valid !== 1'b1 || resp_rdata !== d0 || resp_err !== e0 || req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_hold cyc=%0d got v=%b d=%h e=%b rdy=%b exp v=1 d=%h e=%b rdy=0",
                     s, resp_valid, resp_rdata, resp_err, req_ready, d0, e0);
         end
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      n_total++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL handshake got v=%b rdy=%b exp v=0 rdy=1", resp_valid, req_ready);
      end
   endtask

   task automatic run(input logic rd, input logic wr, input logic sg,
                      input logic [1:0] w, input logic [31:0] a,
                      input logic [63:0] wd, input int stall,
                      output logic [63:0] gd, output logic ge,
                      output logic [63:0] xd, output logic xe);
      issue(rd, wr, sg, w, a, wd, stall, gd, ge);
      model(rd, wr, sg, w, a, wd, xd, xe);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_total++;
      if (resp_valid !== 1'b0 || resp_rdata !== 64'h0 || resp_err !== 1'b0 || req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_state got v=%b d=%h e=%b rdy=%b exp v=0 d=0 e=0 rdy=1",
                  resp_valid, resp_rdata, resp_err, req_ready);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_init();
      logic [63:0] gd, xd;
      logic ge, xe;
      for (int i = 0; i < 32; i++) begin
         run(1'b0, 1'b1, 1'b0, 2'b11, 32'(i*8), {$urandom, $urandom}, 0, gd, ge, xd, xe);
         n_total++;
         if (gd !== 64'h0 || ge !== 1'b0) begin
            n_bad++;
            $display("FAIL init_store idx=%0d got d=%h e=%b exp d=0 e=0", i, gd, ge);
         end
      end
   endtask

   task automatic test_store_double();
      logic [63:0] gd, xd;
      logic ge, xe;
      run(1'b0, 1'b1, 1'b0, 2'b11, 32'h10, 64'h8877665544332211, 0, gd, ge, xd, xe);
      n_total++;
      if (gd !== 64'h0 || ge !== 1'b0) begin
         n_bad++;
         $display("FAIL sd_resp got d=%h e=%b exp d=0 e=0", gd, ge);
      end
      run(1'b1, 1'b0, 1'b0, 2'b10, 32'h14, 64'h0, 0, gd, ge, xd, xe);
      n_total++;
      if (gd !== 64'hFFFFFFFF88776655 || ge !== 1'b0) begin
         n_bad++;
         $display("FAIL lw_sext got d=%h e=%b exp d=ffffffff88776655 e=0", gd, ge);
      end
   endtask

   task automatic test_byte_extend();
      logic [63:0] gd, xd;
      logic ge, xe;
      run(1'b1, 1'b0, 1'b0, 2'b00, 32'h17, 64'h0, 0, gd, ge, xd, xe);
      n_total++;
      if (gd !== 64'hFFFFFFFFFFFFFF88 || ge !== 1'b0) begin
         n_bad++;
         $display("FAIL lb got d=%h e=%b exp d=ffffffffffffff88 e=0", gd, ge);
      end
      run(1'b1, 1'b0, 1'b1, 2'b00, 32'h17, 64'h0, 0, gd, ge, xd, xe);
      n_total++;
      if (gd !== 64'h0000000000000088 || ge !== 1'b0) begin
         n_bad++;
         $display("FAIL lbu got d=%h e=%b exp d=0000000000000088 e=0", gd, ge);
      end
      run(1'b1, 1'b0, 1'b0, 2'b01, 32'h10, 64'h0, 0, gd, ge, xd, xe);
      n_total++;
      if (gd !== 64'h0000000000002211 || ge !== 1'b0) begin
         n_bad++;
         $display("FAIL lh got d=%h e=%b exp d=0000000000002211 e=0", gd, ge);
      end
   endtask

   task automatic test_partial_store();
      logic [63:0] gd, xd;
      logic ge, xe;
      run(1'b0, 1'b1, 1'b0, 2'b00, 32'h12, 64'hFFFFFFFFFFFFFFAB, 0, gd, ge, xd, xe);
      n_total++;
      if (gd !== 64'h0 || ge !== 1'b0) begin
         n_bad++;
         $display("FAIL sb_resp got d=%h e=%b exp d=0 e=0", gd, ge);
      end
      run(1'b1, 1'b0, 1'b0, 2'b11, 32'h10, 64'h0, 0, gd, ge, xd, xe);
      n_total++;
      if (gd !== 64'h8877665544AB2211 || ge !== 1'b0) begin
         n_bad++;
         $display("FAIL sb_merge got d=%h e=%b exp d=8877665544ab2211 e=0", gd, ge);
      end
   endtask

   task automatic test_errors();
      logic [63:0] gd, xd;
      logic ge, xe;
      run(1'b0, 1'b1, 1'b0, 2'b01, 32'h11, 64'hDEAD, 0, gd, ge, xd, xe);
      n_total++;
      if (gd !== 64'h0 || ge !== 1'b1) begin
         n_bad++;
         $display("FAIL err_misalign got d=%h e=%b exp d=0 e=1", gd, ge);
      end
      run(1'b0, 1'b1, 1'b0, 2'b10, 32'h1002, 64'hBEEF, 0, gd, ge, xd, xe);
      n_total++;
      if (gd !== 64'h0 || ge !== 1'b1) begin
         n_bad++;
         $display("FAIL err_sw_1002 got d=%h e=%b exp d=0 e=1", gd, ge);
      end
      run(1'b1, 1'b0, 1'b0, 2'b11, 32'h1000, 64'h0, 0, gd, ge, xd, xe);
      n_total++;
      if (gd !== 64'h0 || ge !== 1'b1) begin
         n_bad++;
         $display("FAIL err_oor got d=%h e=%b exp d=0 e=1", gd, ge);
      end
      run(1'b1, 1'b1, 1'b0, 2'b11, 32'h10, 64'h1111111111111111, 0, gd, ge, xd, xe);
      n_total++;
      if (gd !== 64'h0 || ge !== 1'b1) begin
         n_bad++;
         $display("FAIL err_rd_wr got d=%h e=%b exp d=0 e=1", gd, ge);
      end
      run(1'b0, 1'b0, 1'b0, 2'b11, 32'h10, 64'h2222222222222222, 0, gd, ge, xd, xe);
      n_total++;
      if (gd !== 64'h0 || ge !== 1'b1) begin
         n_bad++;
         $display("FAIL err_no_cmd got d=%h e=%b exp d=0 e=1", gd, ge);
      end
      run(1'b1, 1'b0, 1'b0, 2'b11, 32'h10, 64'h0, 0, gd, ge, xd, xe);
      n_total++;
      if (gd !== 64'h8877665544AB2211 || ge !== 1'b0) begin
         n_bad++;
         $display("FAIL err_no_write got d=%h e=%b exp d=8877665544ab2211 e=0", gd, ge);
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] gd, xd;
      logic ge, xe;
      run(1'b1, 1'b0, 1'b1, 2'b10, 32'h14, 64'h0, 5, gd, ge, xd, xe);
      n_total++;
      if (gd !== 64'h0000000088776655 || ge !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_lwu got d=%h e=%b exp d=0000000088776655 e=0", gd, ge);
      end
      run(1'b0, 1'b1, 1'b0, 2'b01, 32'h13, 64'h0, 5, gd, ge, xd, xe);
      n_total++;
      if (gd !== 64'h0 || ge !== 1'b1) begin
         n_bad++;
         $display("FAIL bp_err got d=%h e=%b exp d=0 e=1", gd, ge);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [63:0] gd, xd;
      logic ge, xe;
      @(negedge clk);
      req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; mem_sign = 1'b0;
      mem_width = 2'b11; addr = 32'h20; wdata = 64'h1234;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_mid_wait got v=%b rdy=%b exp v=0 rdy=1", resp_valid, req_ready);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      // The discarded store is not applied to the model.
      run(1'b1, 1'b0, 1'b0, 2'b11, 32'h20, 64'h0, 0, gd, ge, xd, xe);
      n_total++;
      if (gd !== xd || ge !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_no_write got d=%h e=%b exp d=%h e=0", gd, ge, xd);
      end
   endtask

   task automatic test_random();
      logic [63:0] gd, xd, wd;
      logic ge, xe, rd, wr, sg;
      logic [1:0]  w;
      logic [31:0] a;
      int k;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 9) == 0) a = 32'h1000 + 32'($urandom_range(0, 4095));
         else                           a = 32'($urandom_range(0, 255));
         k = int'($urandom_range(0, 7));
         if (k == 0)      begin rd = 1'b0; wr = 1'b0; end
         else if (k == 1) begin rd = 1'b1; wr = 1'b1; end
         else if (k < 5)  begin rd = 1'b1; wr = 1'b0; end
         else             begin rd = 1'b0; wr = 1'b1; end
         sg = 1'($urandom_range(0, 1));
         w  = 2'($urandom_range(0, 3));
         wd = {$urandom, $urandom};
         run(rd, wr, sg, w, a, wd, int'($urandom_range(0, 2)), gd, ge, xd, xe);
         n_total++;
         if (gd !== xd || ge !== xe) begin
            n_bad++;
            $display("FAIL rand i=%0d rd=%b wr=%b sg=%b w=%0d a=%h got d=%h e=%b exp d=%h e=%b",
                     i, rd, wr, sg, w, a, gd, ge, xd, xe);
         end
      end
   endtask

   // ---------------- sequence ----------------
   initial begin
      n_total    = 0;
      n_bad      = 0;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_sign   = 1'b0;
      mem_width  = 2'b00;
      addr       = 32'h0;
      wdata      = 64'h0;
      resp_ready = 1'b0;
      test_reset();
      test_init();
      test_store_double();
      test_byte_extend();
      test_partial_store();
      test_errors();
      test_backpressure();
      test_reset_mid_op();
      test_random();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
